// File: rtl/prescaler_prog.sv
// Runtime-programmable clock-enable prescaler with loadable modulus, start/stop and one-shot mode.
// Optional square-wave output on sq is enabled by defining PRESCALER_SQ_OUT_EN.
module prescaler_prog #(
  parameter int unsigned WIDTH       = 29,
  parameter int unsigned DEFAULT_MOD = 50000000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic             load,
  input  logic [WIDTH-1:0] mod_in,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  output logic             co,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             sq
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             mode_q, mode_d;   // 1 = one-shot, 0 = periodic
  logic             term_c;

  assign term_c = (count_q == (mod_q - WIDTH'(1)));
  assign co     = (state_q == RUN) & ce & term_c & ~load;
  assign busy   = (state_q == RUN);
  assign count  = count_q;

  // Strobe priority: load, then stop, then start, then normal counting.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mod_d   = mod_q;
    mode_d  = mode_q;
    if (load) begin
      mod_d   = (mod_in == '0) ? WIDTH'(1) : mod_in;
      count_d = '0;
    end else if (stop) begin
      if (state_q == RUN) state_d = IDLE;
    end else if (start && (state_q == IDLE)) begin
      state_d = RUN;
      count_d = '0;
      mode_d  = oneshot;
    end else if ((state_q == RUN) && ce) begin
      if (term_c) begin
        count_d = '0;
        if (mode_q) state_d = IDLE;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= RUN;
      count_q <= '0;
      mod_q   <= WIDTH'(DEFAULT_MOD);
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mod_q   <= mod_d;
      mode_q  <= mode_d;
    end
  end

`ifdef PRESCALER_SQ_OUT_EN
  logic sq_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)     sq_q <= 1'b0;
    else if (co) sq_q <= ~sq_q;
  end

  assign sq = sq_q;
`else
  assign sq = 1'b0;
`endif

endmodule

// File: tb/tb_prescaler_prog.sv
// Self-checking bench for prescaler_prog (WIDTH=4, DEFAULT_MOD=5): vector table plus scoreboard.
module tb_prescaler_prog;

  localparam int unsigned W = 4;

  logic         clk;
  logic         clr;
  logic         ce;
  logic         load;
  logic [W-1:0] mod_in;
  logic         start;
  logic         stop;
  logic         oneshot;
  logic         co;
  logic         busy;
  logic [W-1:0] count;
  logic         sq;

  prescaler_prog #(.WIDTH(W), .DEFAULT_MOD(5)) dut (
    .clk(clk), .clr(clr), .ce(ce), .load(load), .mod_in(mod_in),
    .start(start), .stop(stop), .oneshot(oneshot),
    .co(co), .busy(busy), .count(count), .sq(sq)
  );

  typedef struct {
    logic         ce;
    logic         load;
    logic [W-1:0] mod_in;
    logic         start;
    logic         stop;
    logic         oneshot;
    logic         e_co;
    logic         e_busy;
    logic [W-1:0] e_cnt;
  } vec_t;

  typedef struct {
    logic         co;
    logic         busy;
    logic [W-1:0] cnt;
    logic         sq;
  } exp_t;

  int   errors;
  int   checks;
  exp_t sb[$];
  vec_t tbl[$];
  logic sq_exp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic c, input logic ld, input logic [W-1:0] m,
                              input logic st, input logic sp, input logic os,
                              input logic eco, input logic eb, input logic [W-1:0] ec);
    vec_t v;
    v.ce = c; v.load = ld; v.mod_in = m; v.start = st; v.stop = sp; v.oneshot = os;
    v.e_co = eco; v.e_busy = eb; v.e_cnt = ec;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
  task automatic step(input vec_t v);
    exp_t e;
    exp_t g;
    ce = v.ce; load = v.load; mod_in = v.mod_in;
    start = v.start; stop = v.stop; oneshot = v.oneshot;
    e.co = v.e_co; e.busy = v.e_busy; e.cnt = v.e_cnt; e.sq = sq_exp;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at t=%0t: got 0 entries expected 1", $time);
    end else begin
      g = sb.pop_front();
      check("co",    W'(co),   W'(g.co));
      check("busy",  W'(busy), W'(g.busy));
      check("count", count,    g.cnt);
      check("sq",    W'(sq),   W'(g.sq));
`ifdef PRESCALER_SQ_OUT_EN
      if (g.co) sq_exp = ~sq_exp;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0; checks = 0; sq_exp = 1'b0;
    clr = 1'b1; ce = 1'b0; load = 1'b0; mod_in = '0;
    start = 1'b0; stop = 1'b0; oneshot = 1'b0;

    // Periodic, modulus 5, ce held high.
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, (i % 5) == 4, 1, W'(i % 5)));
    // Load modulus 3 at count 2, then run; load on a terminal count suppresses co.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 1, 2));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, (i % 3) == 2, 1, W'(i % 3)));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 1, 2));
    // Stop at count 2, hold while idle, then a one-shot run.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 1, 2));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 2));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, i == 4, 1, W'(i)));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    // Modulus 0 stored as 1; start+stop while idle stays idle.
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0));
    // Back to modulus 5 (load on terminal count, co held low), then ce toggling 1010...
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 20; i++)
      tbl.push_back(mk((i % 2) == 0, 0, 0, 0, 0, 0,
                       ((i % 2) == 0) && ((((i + 1) / 2) % 5) == 4), 1, W'(((i + 1) / 2) % 5)));
    // Load modulus 3 and count to 2 ahead of the asynchronous clear.
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1));

    // Reset state.
    @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_busy",  W'(busy), 1);
    check("rst_co",    W'(co), 0);
    check("rst_sq",    W'(sq), 0);
    clr = 1'b0;

    foreach (tbl[i]) step(tbl[i]);

    // Asynchronous clear between edges: count drops at once, modulus back to 5.
    #2;
    ce  = 1'b0;
    clr = 1'b1;
    #1;
    check("aclr_count", count, 0);
    check("aclr_busy",  W'(busy), 1);
    check("aclr_sq",    W'(sq), 0);
    sq_exp = 1'b0;
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) step(mk(1, 0, 0, 0, 0, 0, (i % 5) == 4, 1, W'(i % 5)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
